// File: rtl/sr_piso_tx_pkg.sv
// sr_pkg: shared state encoding, divider default and counter sizing for the serial link.
package sr_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, SHIFT = 2'd2} state_e;
    localparam int DIV_W_DEF = 28;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/sr_piso_tx_if.sv
// sr_piso_tx_if: load handshake, shift enable and serial/debug outputs of the transmitter.
interface sr_piso_tx_if #(parameter int WIDTH = 4);
    logic             CE;
    logic             LOAD_VALID;
    logic             LOAD_READY;
    logic [WIDTH-1:0] D;
    logic             SLO;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] Q;
    modport master (output CE, LOAD_VALID, D, input LOAD_READY, SLO, BUSY, DONE, Q);
    modport slave  (input CE, LOAD_VALID, D, output LOAD_READY, SLO, BUSY, DONE, Q);
endinterface

// File: rtl/sr_piso_tx_tick_gen.sv
// tick_gen: free-running divider producing a one-cycle enable every 2^DIV_W clocks.
module tick_gen import sr_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic CLK,
    input  logic R,
    output logic tick
);
    logic [DIV_W-1:0] div_q, div_d;
    always_comb div_d = div_q + DIV_W'(1);
    always_ff @(posedge CLK) begin
        if (R) div_q <= '0;
        else   div_q <= div_d;
    end
    assign tick = &div_q;
endmodule

// File: rtl/sr_piso_tx.sv
// sr_piso_tx: parallel-in serial-out transmitter, MSB first, one bit per qualified tick period.
module sr_piso_tx import sr_pkg::*; #(
    parameter int WIDTH = 4,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic CLK,
    input  logic R,
    sr_piso_tx_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             slo_q, slo_d, done_q, done_d;
    logic             tick, qtick;
    tick_gen #(.DIV_W(DIV_W)) u_tick (.CLK(CLK), .R(R), .tick(tick));
    assign qtick = tick & bus.CE;
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:  if (bus.LOAD_VALID) begin
                       q_d     = bus.D;
                       cnt_d   = CW'(WIDTH);
                       state_d = ARM;
                   end
            ARM:   if (qtick) state_d = SHIFT;
            SHIFT: if (qtick) begin
                       if (cnt_q == CW'(1)) begin
                           q_d     = '0;
                           cnt_d   = '0;
                           done_d  = 1'b1;
                           state_d = IDLE;
                       end else begin
                           q_d   = {q_q[WIDTH-2:0], 1'b0};
                           cnt_d = cnt_q - CW'(1);
                       end
                   end
            default: state_d = IDLE;
        endcase
        // SLO follows the next state so it is a clean flop output aligned with Q
        slo_d = (state_d == SHIFT) & q_d[WIDTH-1];
    end
    always_ff @(posedge CLK) begin
        if (R) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            slo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            slo_q   <= slo_d;
            done_q  <= done_d;
        end
    end
    assign bus.LOAD_READY = (state_q == IDLE);
    assign bus.BUSY       = (state_q != IDLE);
    assign bus.SLO        = slo_q;
    assign bus.DONE       = done_q;
    assign bus.Q          = q_q;
endmodule

// File: tb/tb_sr_piso_tx.sv
// tb_sr_piso_tx: scenario tasks plus a cycle monitor holding a bit/word scoreboard and loopback receiver.
module tb_sr_piso_tx;
    logic clk = 1'b0;
    logic r;
    always #5 clk = ~clk;
    sr_piso_tx_if #(.WIDTH(4)) bus();
    sr_piso_tx #(.WIDTH(4), .DIV_W(2)) dut (.CLK(clk), .R(r), .bus(bus));
    int tests = 0, fails = 0;
    logic p_ok = 1'b0, p_r, p_ce, p_lv, p_slo;
    logic [3:0] p_d;
    int m_div = 0, m_state = 0, m_cnt = 0;
    bit m_done = 0, m_live = 0;
    bit exp_bits[$];
    logic [3:0] exp_words[$];
    logic [3:0] rx = '0, rx_done = '0, w;
    int done_cnt = 0;
    // Behavioural model: applies the edge just passed using inputs captured half a cycle before it
    always @(negedge clk) begin
        bit qt;
        if (p_ok) begin
            qt = 0;
            m_done = 0;
            if (p_r === 1'b1) begin
                m_div = 0; m_state = 0; exp_bits.delete(); exp_words.delete(); m_live = 1;
            end else begin
                qt = (m_div == 3) && (p_ce === 1'b1);
                if (m_state == 0) begin
                    if (p_lv === 1'b1) begin
                        for (int i = 3; i >= 0; i--) exp_bits.push_back(p_d[i]);
                        exp_words.push_back(p_d);
                        m_state = 1;
                    end
                end else if (m_state == 1) begin
                    if (qt) begin m_state = 2; m_cnt = 4; end
                end else if (qt) begin
                    void'(exp_bits.pop_front());
                    m_cnt--;
                    if (m_cnt == 0) begin m_state = 0; m_done = 1; end
                end
                m_div = (m_div + 1) % 4;
                if (qt) rx = {rx[2:0], p_slo};
            end
        end
        if (m_live) begin
            tests++;
            if (bus.SLO !== ((m_state == 2) ? exp_bits[0] : 1'b0)) begin
                fails++; $display("FAIL slo t=%0t got=%b exp=%b", $time, bus.SLO, (m_state == 2) ? exp_bits[0] : 1'b0);
            end
            tests++;
            if (bus.BUSY !== (m_state != 0) || bus.LOAD_READY !== (m_state == 0)) begin
                fails++; $display("FAIL busy_ready t=%0t got=%b%b exp=%b%b", $time, bus.BUSY, bus.LOAD_READY, m_state != 0, m_state == 0);
            end
            tests++;
            if (bus.DONE !== m_done) begin
                fails++; $display("FAIL done t=%0t got=%b exp=%b", $time, bus.DONE, m_done);
            end
            if (m_done) begin
                done_cnt++;
                rx_done = rx;
                w = exp_words.size() ? exp_words.pop_front() : 4'bxxxx;
                tests++;
                if (rx !== w) begin
                    fails++; $display("FAIL loopback t=%0t got=%b exp=%b", $time, rx, w);
                end
            end
        end
        p_ok = 1'b1; p_r = r; p_ce = bus.CE; p_lv = bus.LOAD_VALID; p_d = bus.D; p_slo = bus.SLO;
    end
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (bus.BUSY === 1'b0) begin ok = 1; break; end
        end
    endtask
    task automatic load(input logic [3:0] d);
        bus.LOAD_VALID = 1'b1; bus.D = d;
        cyc(1);
        bus.LOAD_VALID = 1'b0;
    endtask
    task automatic test_reset;
        r = 1'b1;
        cyc(2);
        tests++;
        if (bus.Q !== 4'b0000 || bus.SLO !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.LOAD_READY !== 1'b1) begin
            fails++; $display("FAIL reset_outputs got Q=%b slo=%b busy=%b done=%b rdy=%b", bus.Q, bus.SLO, bus.BUSY, bus.DONE, bus.LOAD_READY);
        end
        tests++;
        if (dut.u_tick.div_q !== 2'd0) begin
            fails++; $display("FAIL reset_div got=%0d exp=0", dut.u_tick.div_q);
        end
        r = 1'b0;
    endtask
    task automatic test_basic;
        bit ok;
        int d0 = done_cnt;
        bus.CE = 1'b1;
        load(4'b1011);
        tests++;
        if (bus.BUSY !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b exp=1", bus.BUSY); end
        wait_idle(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL basic_timeout busy=%b exp=0", bus.BUSY); end
        cyc(1);
        tests++;
        if (done_cnt - d0 != 1 || rx_done !== 4'b1011) begin
            fails++; $display("FAIL basic_frame got dones=%0d rx=%b exp dones=1 rx=1011", done_cnt - d0, rx_done);
        end
    endtask
    task automatic test_ce_freeze;
        bit ok;
        logic [3:0] q0;
        logic s0;
        int d0 = done_cnt;
        load(4'b1101);
        for (int i = 0; i < 100 && !(m_state == 2 && exp_bits.size() == 3); i++) cyc(1);
        cyc(1);
        bus.CE = 1'b0;
        q0 = bus.Q; s0 = bus.SLO;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            tests++;
            if (bus.Q !== q0 || bus.SLO !== s0) begin
                fails++; $display("FAIL ce_freeze got Q=%b slo=%b exp Q=%b slo=%b", bus.Q, bus.SLO, q0, s0);
            end
        end
        bus.CE = 1'b1;
        wait_idle(ok);
        cyc(1);
        tests++;
        if (!ok || done_cnt - d0 != 1 || rx_done !== 4'b1101) begin
            fails++; $display("FAIL ce_frame got ok=%0d dones=%0d rx=%b exp ok=1 dones=1 rx=1101", ok, done_cnt - d0, rx_done);
        end
    endtask
    task automatic test_ignore_busy;
        bit ok;
        int d0 = done_cnt;
        load(4'b1011);
        cyc(2);
        bus.LOAD_VALID = 1'b1; bus.D = 4'b0110;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            tests++;
            if (bus.LOAD_READY !== 1'b0) begin fails++; $display("FAIL ignore_ready got=%b exp=0", bus.LOAD_READY); end
        end
        bus.LOAD_VALID = 1'b0;
        wait_idle(ok);
        cyc(4);
        tests++;
        if (!ok || done_cnt - d0 != 1 || rx_done !== 4'b1011) begin
            fails++; $display("FAIL ignore_frame got ok=%0d dones=%0d rx=%b exp ok=1 dones=1 rx=1011", ok, done_cnt - d0, rx_done);
        end
    endtask
    task automatic test_reset_mid;
        bit ok;
        int d0;
        load(4'b1011);
        for (int i = 0; i < 100 && !(m_state == 2 && exp_bits.size() == 2); i++) cyc(1);
        r = 1'b1;
        cyc(1);
        r = 1'b0;
        tests++;
        if (bus.Q !== 4'b0000 || bus.SLO !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || dut.u_tick.div_q !== 2'd0) begin
            fails++; $display("FAIL abort_state got Q=%b slo=%b busy=%b done=%b div=%0d exp 0000/0/0/0/0", bus.Q, bus.SLO, bus.BUSY, bus.DONE, dut.u_tick.div_q);
        end
        d0 = done_cnt;
        cyc(10);
        tests++;
        if (done_cnt != d0) begin fails++; $display("FAIL abort_nodone got=%0d exp=0", done_cnt - d0); end
        load(4'b0001);
        wait_idle(ok);
        cyc(1);
        tests++;
        if (!ok || done_cnt - d0 != 1 || rx_done !== 4'b0001) begin
            fails++; $display("FAIL abort_reload got ok=%0d dones=%0d rx=%b exp ok=1 dones=1 rx=0001", ok, done_cnt - d0, rx_done);
        end
    endtask
    task automatic test_back_to_back;
        bit ok, seen;
        int d0 = done_cnt;
        load(4'b1011);
        bus.LOAD_VALID = 1'b1; bus.D = 4'b1100;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (bus.DONE === 1'b1) begin seen = 1; break; end
        end
        tests++;
        if (!seen || bus.LOAD_READY !== 1'b1) begin fails++; $display("FAIL b2b_done got seen=%0d rdy=%b exp 1/1", seen, bus.LOAD_READY); end
        cyc(1);
        bus.LOAD_VALID = 1'b0;
        tests++;
        if (bus.BUSY !== 1'b1) begin fails++; $display("FAIL b2b_accept got=%b exp=1", bus.BUSY); end
        wait_idle(ok);
        cyc(1);
        tests++;
        if (!ok || done_cnt - d0 != 2 || rx_done !== 4'b1100) begin
            fails++; $display("FAIL b2b_frame got ok=%0d dones=%0d rx=%b exp ok=1 dones=2 rx=1100", ok, done_cnt - d0, rx_done);
        end
    endtask
    initial begin
        r = 1'b1; bus.CE = 1'b0; bus.LOAD_VALID = 1'b0; bus.D = '0;
        test_reset;
        test_basic;
        test_ce_freeze;
        test_ignore_busy;
        test_reset_mid;
        test_back_to_back;
        cyc(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end
endmodule
